// File: rtl/div_sched_pkg.sv
// Shared types for the divider scheduler: FSM states, the divide-by-zero quotient
// and the response record.
package div_sched_pkg;

  // The response record is sized for the shipped configuration (4 requesters, 16-bit operands).
  localparam int RSP_WIDTH = 16;
  localparam int RSP_IDW   = 2;

  localparam logic [RSP_WIDTH-1:0] DZ_QUOTIENT = '1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    RESP
  } state_e;

  typedef struct packed {
    logic [RSP_IDW-1:0]   id;
    logic [RSP_WIDTH-1:0] quotient;
    logic [RSP_WIDTH-1:0] remainder;
    logic                 dz;
    logic                 timeout;
  } rsp_t;

endpackage

// File: rtl/div_sched_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter
  import div_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx,
  output logic            any
);

  always_comb begin
    int j;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    j       = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!any && req[j]) begin
        any     = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/div_sched_ctrl.sv
// Shares one divider among NREQ requesters with round-robin arbitration and a tagged response.
// Optional RUN-state watchdog enabled by defining DIV_TIMEOUT_EN.
//
// state | meaning
// IDLE  | arbitrate; accept one request, latch operands and id
// LOAD  | one-cycle div_load pulse
// RUN   | div_enable held until div_done (or watchdog expiry)
// RESP  | rsp_valid held with stable payload until rsp_ready
module div_sched_ctrl
  import div_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 16,
  parameter int IDW     = $clog2(NREQ),
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_dividend,
  input  logic [NREQ*WIDTH-1:0] req_divisor,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_quotient,
  output logic [WIDTH-1:0]      rsp_remainder,
  output logic                  rsp_dz,
  output logic                  rsp_timeout,
  output logic                  div_load,
  output logic                  div_enable,
  output logic [WIDTH-1:0]      div_dividend,
  output logic [WIDTH-1:0]      div_divisor,
  input  logic [WIDTH-1:0]      div_quotient,
  input  logic [WIDTH-1:0]      div_remainder,
  input  logic                  div_done,
  output logic                  sched_busy
);

  if (NREQ < 2 || WIDTH != RSP_WIDTH || IDW != RSP_IDW || TIMEOUT < 1) begin : g_param_err
    $error("div_sched_ctrl: parameters do not match the div_sched_pkg response record");
  end

  state_e           state, state_n;
  logic [IDW-1:0]   ptr, gnt_idx;
  logic [NREQ-1:0]  gnt;
  logic             any, accept, run_tmo;
  logic [WIDTH-1:0] sel_dividend, sel_divisor;
  logic [WIDTH-1:0] op_dividend, op_divisor;
  rsp_t             rsp_q;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign accept       = (state == IDLE) && any;
  assign sel_dividend = req_dividend[int'(gnt_idx)*WIDTH +: WIDTH];
  assign sel_divisor  = req_divisor[int'(gnt_idx)*WIDTH +: WIDTH];

`ifdef DIV_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT + 1);
  logic [TCW-1:0] tmo_cnt;

  // Loaded during LOAD so RUN lasts exactly TIMEOUT cycles before expiry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if (state == LOAD) begin
      tmo_cnt <= TCW'(TIMEOUT - 1);
    end else if (state == RUN && tmo_cnt != '0) begin
      tmo_cnt <= tmo_cnt - 1'b1;
    end
  end

  assign run_tmo = (state == RUN) && !div_done && (tmo_cnt == '0);
`else
  assign run_tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = (sel_divisor == '0) ? RESP : LOAD;
      LOAD: state_n = RUN;
      RUN:  if (div_done || run_tmo) state_n = RESP;
      RESP: if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr         <= '0;
      op_dividend <= '0;
      op_divisor  <= '0;
      rsp_q       <= '0;
    end else begin
      if (accept) begin
        ptr         <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        op_dividend <= sel_dividend;
        op_divisor  <= sel_divisor;
        rsp_q.id    <= gnt_idx;
        // Divide-by-zero is answered directly without involving the divider.
        if (sel_divisor == '0) begin
          rsp_q.quotient  <= DZ_QUOTIENT;
          rsp_q.remainder <= sel_dividend;
          rsp_q.dz        <= 1'b1;
        end
      end
      if (state == RUN) begin
        if (div_done) begin
          rsp_q.quotient  <= div_quotient;
          rsp_q.remainder <= div_remainder;
        end else if (run_tmo) begin
          rsp_q.quotient  <= '0;
          rsp_q.remainder <= '0;
          rsp_q.timeout   <= 1'b1;
        end
      end
      if (state == RESP && rsp_ready) begin
        rsp_q.dz      <= 1'b0;
        rsp_q.timeout <= 1'b0;
      end
    end
  end

  assign req_ready     = (state == IDLE) ? gnt : '0;
  assign div_load      = (state == LOAD);
  assign div_enable    = (state == RUN);
  assign rsp_valid     = (state == RESP);
  assign sched_busy    = (state != IDLE);
  assign div_dividend  = op_dividend;
  assign div_divisor   = op_divisor;
  assign rsp_id        = rsp_q.id;
  assign rsp_quotient  = rsp_q.quotient;
  assign rsp_remainder = rsp_q.remainder;
  assign rsp_dz        = rsp_q.dz;
  assign rsp_timeout   = rsp_q.timeout;

endmodule

// File: tb/tb_div_sched_ctrl.sv
// Directed bench for div_sched_ctrl with a small behavioural divider (4 enable cycles to done).
module tb_div_sched_ctrl;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_dividend = '0;
  logic [NREQ*WIDTH-1:0] req_divisor = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b1;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_quotient, rsp_remainder;
  logic                  rsp_dz, rsp_timeout;
  logic                  div_load, div_enable;
  logic [WIDTH-1:0]      div_dividend, div_divisor;
  logic [WIDTH-1:0]      div_quotient = '0;
  logic [WIDTH-1:0]      div_remainder = '0;
  logic                  div_done = 1'b0;
  logic                  sched_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_sched_ctrl #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_dz(rsp_dz), .rsp_timeout(rsp_timeout),
    .div_load(div_load), .div_enable(div_enable),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .div_done(div_done), .sched_busy(sched_busy)
  );

  // Divider stand-in: done one cycle after the 4th enabled cycle; stuck holds done low.
  logic [WIDTH-1:0] m_a = '0, m_b = 16'd1;
  int   m_cnt = 0;
  logic stuck = 1'b0;
  always @(posedge clk) begin
    if (div_load) begin
      m_a <= div_dividend; m_b <= div_divisor; m_cnt <= 3; div_done <= 1'b0;
    end else if (div_done) begin
      div_done <= 1'b0;
    end else if (div_enable && !stuck) begin
      if (m_cnt == 0) begin
        div_done <= 1'b1; div_quotient <= m_a / m_b; div_remainder <= m_a % m_b;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_dividend[i*WIDTH +: WIDTH] = a;
    req_divisor[i*WIDTH +: WIDTH]  = b;
  endtask

  // Called at a negedge; returns at the first negedge with rsp_valid, counting enable cycles.
  task automatic wait_rsp(output bit ok, output int en_cycles);
    ok = 1'b0;
    en_cycles = 0;
    for (int k = 0; k < 40; k++) begin
      if (rsp_valid) begin ok = 1'b1; break; end
      if (div_enable) en_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = '0; rsp_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dz, rsp_timeout,
         div_load, div_enable, div_dividend, div_divisor, sched_busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b load=%b en=%b q=%h r=%h expected all zero",
               sched_busy, div_load, div_enable, rsp_quotient, rsp_remainder);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (sched_busy !== 1'b0) begin errors++; $display("FAIL reset_idle got busy=%b expected 0", sched_busy); end
  endtask

  task automatic test_round_robin();
    bit ok; int en;
    set_req(1, 16'd20, 16'd6); set_req(2, 16'd50, 16'd7);
    req_valid = 4'b0110; #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL rr_first got ready=%b expected 0010", req_ready); end
    @(negedge clk); req_valid = 4'b0100; #1;
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL rr_busy_ready got ready=%b expected 0000", req_ready); end
    wait_rsp(ok, en);
    checks++;
    if (!ok || rsp_id !== 2'd1 || rsp_quotient !== 16'd3 || rsp_remainder !== 16'd2) begin
      errors++; $display("FAIL rr_rsp1 got ok=%b id=%0d q=%0d r=%0d expected id=1 q=3 r=2", ok, rsp_id, rsp_quotient, rsp_remainder);
    end
    @(negedge clk); #1;
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL rr_second got ready=%b expected 0100", req_ready); end
    @(negedge clk); req_valid = '0;
    wait_rsp(ok, en);
    checks++;
    if (!ok || rsp_id !== 2'd2 || rsp_quotient !== 16'd7 || rsp_remainder !== 16'd1) begin
      errors++; $display("FAIL rr_rsp2 got ok=%b id=%0d q=%0d r=%0d expected id=2 q=7 r=1", ok, rsp_id, rsp_quotient, rsp_remainder);
    end
    @(negedge clk);
    set_req(0, 16'd30, 16'd4); set_req(3, 16'd9, 16'd2);
    req_valid = 4'b1001; #1;
    checks++;
    if (req_ready !== 4'b1000) begin errors++; $display("FAIL rr_wrap_first got ready=%b expected 1000", req_ready); end
    @(negedge clk); req_valid = 4'b0001;
    wait_rsp(ok, en);
    checks++;
    if (!ok || rsp_id !== 2'd3 || rsp_quotient !== 16'd4 || rsp_remainder !== 16'd1) begin
      errors++; $display("FAIL rr_rsp3 got ok=%b id=%0d q=%0d r=%0d expected id=3 q=4 r=1", ok, rsp_id, rsp_quotient, rsp_remainder);
    end
    @(negedge clk); #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL rr_wrap_second got ready=%b expected 0001", req_ready); end
    @(negedge clk); req_valid = '0;
    wait_rsp(ok, en);
    checks++;
    if (!ok || rsp_id !== 2'd0 || rsp_quotient !== 16'd7 || rsp_remainder !== 16'd2) begin
      errors++; $display("FAIL rr_rsp0 got ok=%b id=%0d q=%0d r=%0d expected id=0 q=7 r=2", ok, rsp_id, rsp_quotient, rsp_remainder);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok; int en;
    set_req(0, 16'd7, 16'd3);
    req_valid = 4'b0001; #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL basic_ready got %b expected 0001", req_ready); end
    @(negedge clk); req_valid = '0; #1;
    checks++;
    if (div_load !== 1'b1 || div_enable !== 1'b0 || div_dividend !== 16'd7 || div_divisor !== 16'd3 || sched_busy !== 1'b1) begin
      errors++; $display("FAIL basic_load got load=%b en=%b a=%0d b=%0d expected load=1 en=0 a=7 b=3", div_load, div_enable, div_dividend, div_divisor);
    end
    @(negedge clk); #1;
    checks++;
    if (div_load !== 1'b0 || div_enable !== 1'b1) begin
      errors++; $display("FAIL basic_run got load=%b en=%b expected load=0 en=1", div_load, div_enable);
    end
    wait_rsp(ok, en);
    checks++;
    if (!ok || en != 5) begin errors++; $display("FAIL basic_latency got ok=%b enable_cycles=%0d expected 5", ok, en); end
    checks++;
    if (rsp_id !== 2'd0 || rsp_quotient !== 16'd2 || rsp_remainder !== 16'd1 || rsp_dz !== 1'b0 || rsp_timeout !== 1'b0) begin
      errors++; $display("FAIL basic_rsp got id=%0d q=%0d r=%0d dz=%b to=%b expected 0 2 1 0 0", rsp_id, rsp_quotient, rsp_remainder, rsp_dz, rsp_timeout);
    end
    @(negedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || sched_busy !== 1'b0) begin
      errors++; $display("FAIL basic_done got valid=%b busy=%b expected 0 0", rsp_valid, sched_busy);
    end
  endtask

  task automatic test_div_zero();
    set_req(2, 16'd100, 16'd0);
    req_valid = 4'b0100; #1;
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL dz_ready got %b expected 0100", req_ready); end
    @(negedge clk); req_valid = '0; #1;
    checks++;
    if (rsp_valid !== 1'b1 || div_load !== 1'b0 || div_enable !== 1'b0) begin
      errors++; $display("FAIL dz_bypass got valid=%b load=%b en=%b expected 1 0 0", rsp_valid, div_load, div_enable);
    end
    checks++;
    if (rsp_id !== 2'd2 || rsp_quotient !== 16'hFFFF || rsp_remainder !== 16'd100 || rsp_dz !== 1'b1) begin
      errors++; $display("FAIL dz_rsp got id=%0d q=%h r=%0d dz=%b expected 2 ffff 100 1", rsp_id, rsp_quotient, rsp_remainder, rsp_dz);
    end
    @(negedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_dz !== 1'b0 || sched_busy !== 1'b0) begin
      errors++; $display("FAIL dz_clear got valid=%b dz=%b busy=%b expected 0 0 0", rsp_valid, rsp_dz, sched_busy);
    end
  endtask

  task automatic test_backpressure();
    bit ok; int en;
    rsp_ready = 1'b0;
    set_req(0, 16'd9, 16'd4); set_req(3, 16'd9, 16'd2);
    req_valid = 4'b0001; #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_ready got %b expected 0001", req_ready); end
    @(negedge clk); req_valid = 4'b1000;
    wait_rsp(ok, en);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_wait got no response expected rsp_valid"); end
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_quotient !== 16'd2 || rsp_remainder !== 16'd1 || req_ready !== 4'b0000) begin
        errors++; $display("FAIL bp_hold_%0d got valid=%b id=%0d q=%0d r=%0d ready=%b expected 1 0 2 1 0000",
                           c, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, req_ready);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b1000) begin
      errors++; $display("FAIL bp_release got valid=%b ready=%b expected 0 1000", rsp_valid, req_ready);
    end
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    bit ok; int en;
    set_req(1, 16'd7, 16'd3);
    req_valid = 4'b0010;
    @(negedge clk); req_valid = '0;
    @(negedge clk); #1;
    checks++;
    if (div_enable !== 1'b1) begin errors++; $display("FAIL mid_in_run got en=%b expected 1", div_enable); end
    rst = 1'b0; #1;
    checks++;
    if (div_enable !== 1'b0 || sched_busy !== 1'b0 || div_dividend !== '0 || div_divisor !== '0 || rsp_valid !== 1'b0 || rsp_id !== '0) begin
      errors++; $display("FAIL mid_reset got en=%b busy=%b a=%0d b=%0d id=%0d expected all 0", div_enable, sched_busy, div_dividend, div_divisor, rsp_id);
    end
    @(negedge clk); rst = 1'b1;
    set_req(2, 16'd5, 16'd5);
    req_valid = 4'b0110; #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_ptr_cleared got ready=%b expected 0010", req_ready); end
    @(negedge clk); req_valid = '0;
    wait_rsp(ok, en);
    checks++;
    if (!ok || rsp_id !== 2'd1 || rsp_quotient !== 16'd2 || rsp_remainder !== 16'd1) begin
      errors++; $display("FAIL mid_reissue got ok=%b id=%0d q=%0d r=%0d expected id=1 q=2 r=1", ok, rsp_id, rsp_quotient, rsp_remainder);
    end
    @(negedge clk);
  endtask

`ifdef DIV_TIMEOUT_EN
  task automatic test_timeout();
    bit ok; int en;
    stuck = 1'b1;
    set_req(0, 16'd7, 16'd3);
    req_valid = 4'b0001;
    @(negedge clk); req_valid = '0;
    @(negedge clk);
    wait_rsp(ok, en);
    checks++;
    if (!ok || en != 8) begin errors++; $display("FAIL tmo_cycles got ok=%b enable_cycles=%0d expected 8", ok, en); end
    checks++;
    if (rsp_timeout !== 1'b1 || rsp_quotient !== '0 || rsp_remainder !== '0 || rsp_dz !== 1'b0) begin
      errors++; $display("FAIL tmo_rsp got to=%b q=%0d r=%0d dz=%b expected 1 0 0 0", rsp_timeout, rsp_quotient, rsp_remainder, rsp_dz);
    end
    @(negedge clk); #1;
    checks++;
    if (rsp_timeout !== 1'b0 || sched_busy !== 1'b0) begin
      errors++; $display("FAIL tmo_clear got to=%b busy=%b expected 0 0", rsp_timeout, sched_busy);
    end
    stuck = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_basic();
    test_div_zero();
    test_backpressure();
    test_reset_mid_run();
`ifdef DIV_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
